// File: rtl/fifo_fwft_sclk_if.sv
// Producer/consumer handshake bundle for the first-word-fall-through FIFO.
interface fifo_fwft_sclk_if #(
    parameter int DEPTH_WIDTH = 4,
    parameter int DATA_WIDTH  = 32
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic [DEPTH_WIDTH:0]  fill_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, din, rd_en,
        input  full, dout, empty, fill_count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, dout, empty, fill_count, overflow, underflow
    );
endinterface

// File: rtl/fifo_fwft_sclk.sv
// Single-clock FWFT FIFO: RAM with registered read feeds dout directly, head prefetched.
// Latency: first word into an idle FIFO visible two edges after its write; pops reload same edge.
// Backpressure: writes while full are dropped (overflow pulse); pops while empty ignored (underflow pulse).
module fifo_fwft_sclk #(
    parameter int DEPTH_WIDTH = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_fwft_sclk_if.slave  bus
);
    localparam logic [DEPTH_WIDTH:0] CAPACITY = (DEPTH_WIDTH+1)'(1) << DEPTH_WIDTH;
    localparam int unsigned          DEPTH    = 1 << DEPTH_WIDTH;

    typedef enum logic [1:0] {
        HEAD_NONE,
        HEAD_FETCH,
        HEAD_VALID
    } head_state_t;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH-1:0] rd_addr;
    logic [DEPTH_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0]  ram_q;
    logic                   ovf_q;
    logic                   unf_q;
    head_state_t            head_state;
    head_state_t            nxt_state;
    logic                   load_en;
    logic                   full;
    logic                   head_vld;
    logic                   wr_acc;
    logic                   pop;

    assign full     = (count == CAPACITY);
    assign head_vld = (head_state == HEAD_VALID);
    assign wr_acc   = bus.wr_en & ~full;
    assign pop      = bus.rd_en & head_vld;

    // Look ahead past the word being popped so back-to-back pops never bubble.
    assign rd_addr  = rd_ptr + DEPTH_WIDTH'(pop);

    always_comb begin
        nxt_state = head_state;
        load_en   = 1'b0;
        unique case (head_state)
            HEAD_NONE: begin
                if (count != '0) begin
                    nxt_state = HEAD_FETCH;
                    load_en   = 1'b1;
                end
            end
            HEAD_FETCH: begin
                nxt_state = HEAD_VALID;
            end
            HEAD_VALID: begin
                // A word written this same edge counts as a successor via the RAM bypass.
                if (pop) begin
                    if ((count > (DEPTH_WIDTH+1)'(1)) || wr_acc) begin
                        load_en = 1'b1;
                    end else begin
                        nxt_state = HEAD_NONE;
                    end
                end
            end
            default: begin
                nxt_state = HEAD_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_state <= HEAD_NONE;
            ram_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            head_state <= nxt_state;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_addr;
            end
            unique case ({wr_acc, pop})
                2'b10:   count <= count + (DEPTH_WIDTH+1)'(1);
                2'b01:   count <= count - (DEPTH_WIDTH+1)'(1);
                default: count <= count;
            endcase
            if (load_en) begin
                ram_q <= (wr_acc && (wr_ptr == rd_addr)) ? bus.din : mem[rd_addr];
            end
            ovf_q <= bus.wr_en & full;
            unf_q <= bus.rd_en & ~head_vld;
        end
    end

    assign bus.full       = full;
    assign bus.dout       = ram_q;
    assign bus.empty      = ~head_vld;
    assign bus.fill_count = count;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
endmodule
